candy_desc_fetch: RTL and testbench

Avalon-MM read/write master that walks a linked list of 4-word DMA descriptors held in the on-chip descriptor memory (2048 x 32, single port, 1-cycle read latency). It sits between the descriptor memory's slave port and the DMA datapath: it fetches each descriptor, hands it off on a valid/ready stream, optionally writes back the ownership bit, and follows the next pointer until the chain ends, an unowned descriptor is found, or software aborts.

---
 rtl/candy_desc_fetch.sv | 146 ++++++++++++++
 tb/tb_candy_desc_fetch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/candy_desc_fetch.sv
// candy_desc_fetch: Avalon-MM descriptor chain walker; define CANDY_DESC_WRITEBACK_EN to enable ownership write-back
module candy_desc_fetch #(
  parameter int ADDR_W     = 11,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              abort,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_read,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic [31:0]       m_writedata,
  input  logic [31:0]       m_readdata,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [31:0]       desc_src,
  output logic [31:0]       desc_dst,
  output logic [15:0]       desc_len,
  output logic              desc_last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        done_status
);
`ifdef CANDY_DESC_WRITEBACK_EN
  localparam int HI_W = 8;
`else
  localparam int HI_W = 2;
`endif
  typedef enum logic [2:0] {IDLE, READ, DRAIN, CHECK, PRESENT, WRBACK, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, nxt_q, nxt_d;
  logic [1:0] rd_cnt_q, rd_cnt_d, cap_cnt_q, cap_cnt_d, status_q, status_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [31:0] src_q, src_d, dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic [HI_W-1:0] hi_q, hi_d;
  logic cap, hs, owned, last;
  assign cap = vld_q[RD_LATENCY-1];
  assign owned = hi_q[HI_W-1];
  assign last = hi_q[HI_W-2];
  assign m_read = state_q == READ;
`ifdef CANDY_DESC_WRITEBACK_EN
  assign m_write = state_q == WRBACK;
  assign m_byteenable = m_write ? 4'b1000 : 4'hF;
  assign m_writedata = m_write ? {1'b0, hi_q[6:0], 24'h0} : '0;
`else
  assign m_write = 1'b0;
  assign m_byteenable = 4'hF;
  assign m_writedata = '0;
`endif
  assign m_chipselect = m_read | m_write;
  assign m_address = m_read ? base_q + ADDR_W'(rd_cnt_q) : (m_write ? base_q + ADDR_W'(3) : '0);
  assign desc_valid = state_q == PRESENT;
  assign hs = desc_valid & desc_ready;
  assign desc_src = src_q;
  assign desc_dst = dst_q;
  assign desc_len = len_q;
  assign desc_last = last;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign done_status = status_q;
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    status_d = status_q;
    rd_cnt_d = m_read ? rd_cnt_q + 2'd1 : rd_cnt_q;
    cap_cnt_d = cap ? cap_cnt_q + 2'd1 : cap_cnt_q;
    vld_d = RD_LATENCY'({vld_q, m_read});
    src_d = cap && cap_cnt_q == 2'd0 ? m_readdata : src_q;
    dst_d = cap && cap_cnt_q == 2'd1 ? m_readdata : dst_q;
    nxt_d = cap && cap_cnt_q == 2'd2 ? m_readdata[ADDR_W-1:0] : nxt_q;
    len_d = cap && cap_cnt_q == 2'd3 ? m_readdata[15:0] : len_q;
    hi_d = cap && cap_cnt_q == 2'd3 ? m_readdata[31:32-HI_W] : hi_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = READ;
        base_d = start_addr & ~ADDR_W'(3);
        status_d = 2'b00;
      end
      READ: state_d = rd_cnt_q == 2'd3 ? DRAIN : READ;
      DRAIN: state_d = cap && cap_cnt_q == 2'd3 ? CHECK : DRAIN;
      CHECK: if (abort || !owned) begin
        state_d = DONE;
        status_d = abort ? 2'b10 : 2'b01;
      end else begin
        state_d = PRESENT;
      end
`ifdef CANDY_DESC_WRITEBACK_EN
      PRESENT: if (hs) begin
        state_d = abort ? DONE : WRBACK;
        status_d = abort ? 2'b10 : status_q;
      end
      WRBACK: if (last || abort) begin
        state_d = DONE;
        status_d = last ? 2'b00 : 2'b10;
      end else begin
        state_d = READ;
        base_d = nxt_q & ~ADDR_W'(3);
      end
`else
      PRESENT: if (hs) begin
        if (abort || last) begin
          state_d = DONE;
          status_d = abort ? 2'b10 : 2'b00;
        end else begin
          state_d = READ;
          base_d = nxt_q & ~ADDR_W'(3);
        end
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q <= '0;
      nxt_q <= '0;
      rd_cnt_q <= '0;
      cap_cnt_q <= '0;
      status_q <= '0;
      vld_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      hi_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      nxt_q <= nxt_d;
      rd_cnt_q <= rd_cnt_d;
      cap_cnt_q <= cap_cnt_d;
      status_q <= status_d;
      vld_q <= vld_d;
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      hi_q <= hi_d;
    end
  end
endmodule

// File: tb/tb_candy_desc_fetch.sv
// tb_candy_desc_fetch: scoreboard bench with a list-walking reference model and a descriptor memory model
module tb_candy_desc_fetch;
  localparam int AW = 11;
`ifdef CANDY_DESC_WRITEBACK_EN
  localparam bit WB = 1'b1;
  localparam int PER = 8;
`else
  localparam bit WB = 1'b0;
  localparam int PER = 7;
`endif
  typedef struct packed {logic [31:0] src; logic [31:0] dst; logic [15:0] len; logic last;} desc_t;
  typedef struct packed {logic [AW-1:0] a; logic [3:0] be; logic [31:0] d;} wr_t;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, desc_ready = 1'b0;
  logic [AW-1:0] start_addr = '0, m_address;
  logic m_chipselect, m_read, m_write, desc_valid, desc_last, busy, done;
  logic [3:0] m_byteenable;
  logic [31:0] m_writedata, m_readdata, desc_src, desc_dst, rd_q = '0;
  logic [15:0] desc_len;
  logic [1:0] done_status;
  logic [31:0] mem [2048];
  logic [AW-1:0] exp_rd [$];
  desc_t exp_desc [$];
  wr_t exp_wr [$];
  logic [1:0] exp_st [$];
  int checks = 0, errors = 0, cyc = 0, start_cyc = 0, prev_fetch = 0;
  int ab_mode = 0, ab_k = 0, ab_cnt = 0, rdy_mode = 0, stall = 0;
  bit t_pend = 0, have_prev = 0, per_chk = 0, chk_busy = 0;
  candy_desc_fetch #(.ADDR_W(AW), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .abort(abort),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_read(m_read), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_src(desc_src), .desc_dst(desc_dst),
    .desc_len(desc_len), .desc_last(desc_last), .busy(busy), .done(done), .done_status(done_status)
  );
  always #5 clk = ~clk;
  assign m_readdata = rd_q;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (m_read) rd_q <= mem[m_address];
    if (m_write)
      for (int b = 0; b < 4; b++)
        if (m_byteenable[b]) mem[m_address][8*b +: 8] = m_writedata[8*b +: 8];
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    desc_t d;
    wr_t w;
    if (m_read || m_write) chk("chipselect", m_chipselect, 1);
    if (m_read && m_write) chk("rd_wr_overlap", m_write, 0);
    if (m_read) begin
      chk("read_expected", exp_rd.size() > 0, 1);
      if (exp_rd.size() > 0) chk("read_addr", m_address, exp_rd.pop_front());
      if (m_address[1:0] == 2'd0) begin
        if (per_chk && have_prev) chk("desc_period", cyc - prev_fetch, PER);
        have_prev = 1;
        prev_fetch = cyc;
      end
    end
    if (m_write) begin
      chk("write_expected", exp_wr.size() > 0, 1);
      if (exp_wr.size() > 0) begin
        w = exp_wr.pop_front();
        chk("wr_addr", m_address, w.a);
        chk("wr_be", m_byteenable, w.be);
        chk("wr_data", m_writedata, w.d);
      end
    end
    if (desc_valid) begin
      chk("desc_expected", exp_desc.size() > 0, 1);
      if (exp_desc.size() > 0) begin
        d = exp_desc[0];
        chk("desc_fields", {desc_src, desc_dst, desc_len, desc_last}, d);
        if (desc_ready) void'(exp_desc.pop_front());
      end
      if (t_pend) begin
        chk("first_desc_latency", cyc - start_cyc, 7);
        t_pend = 0;
      end
    end
    if (done) begin
      t_pend = 0;
      chk("done_expected", exp_st.size() > 0, 1);
      if (exp_st.size() > 0) chk("done_status", done_status, exp_st.pop_front());
      chk_busy = 1;
    end else if (chk_busy) begin
      chk("busy_after_done", busy, 0);
      chk_busy = 0;
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (desc_valid && !desc_ready) stall++;
    desc_ready = rdy_mode == 0 ? 1'b1 : (rdy_mode == 1 ? 1'($urandom) : stall >= 20);
  end
  initial forever begin
    @(negedge clk);
    if (m_read && m_address[1:0] == 2'd0) begin
      if (ab_mode == 1 && ab_cnt == ab_k) abort = 1'b1;
      ab_cnt++;
    end
    if (ab_mode == 2 && desc_valid && ab_cnt == ab_k + 1) abort = 1'b1;
  end
  task automatic chk_reset();
    chk("rst_m_read", m_read, 0);
    chk("rst_m_write", m_write, 0);
    chk("rst_m_cs", m_chipselect, 0);
    chk("rst_m_addr", m_address, 0);
    chk("rst_m_be", m_byteenable, 4'hF);
    chk("rst_m_wdata", m_writedata, 0);
    chk("rst_desc_valid", desc_valid, 0);
    chk("rst_desc_fields", {desc_src, desc_dst, desc_len, desc_last}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_status", done_status, 0);
  endtask
  task automatic clear_exp();
    exp_rd.delete();
    exp_desc.delete();
    exp_wr.delete();
    exp_st.delete();
    t_pend = 0;
    chk_busy = 0;
    abort = 1'b0;
    ab_mode = 0;
  endtask
  task automatic put_desc(input logic [AW-1:0] b, input logic [31:0] nxt, input bit own, input bit lst, input logic [15:0] len);
    mem[b] = $urandom;
    mem[b + AW'(1)] = $urandom;
    mem[b + AW'(2)] = nxt;
    mem[b + AW'(3)] = {own, lst, 14'($urandom), len};
  endtask
  task automatic run(input logic [AW-1:0] sa, input int am, input int ak, input int rm, input bit do_reset);
    logic [31:0] mm [2048];
    logic [AW-1:0] b;
    logic [31:0] w3;
    logic [1:0] st;
    mm = mem;
    b = sa & ~AW'(3);
    st = 2'b11;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 4; j++) exp_rd.push_back(b + AW'(j));
      w3 = mm[b + AW'(3)];
      if (am == 1 && i == ak) begin st = 2'b10; break; end
      if (!w3[31]) begin st = 2'b01; break; end
      exp_desc.push_back({mm[b], mm[b + AW'(1)], w3[15:0], w3[30]});
      if (am == 2 && i == ak) begin st = 2'b10; break; end
      if (WB) begin
        exp_wr.push_back({b + AW'(3), 4'b1000, {1'b0, w3[30:24], 24'h0}});
        mm[b + AW'(3)][31] = 1'b0;
      end
      if (w3[30]) begin st = 2'b00; break; end
      b = mm[b + AW'(2)][AW-1:0] & ~AW'(3);
    end
    exp_st.push_back(st);
    @(posedge clk);
    #1;
    ab_mode = am;
    ab_k = ak;
    ab_cnt = 0;
    rdy_mode = rm;
    stall = 0;
    have_prev = 0;
    per_chk = rm == 0;
    start_addr = sa;
    start = 1'b1;
    start_cyc = cyc;
    t_pend = 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (do_reset) begin
      for (int i = 0; i < 50 && !(m_read && m_address[1:0] == 2'd1); i++) begin
        @(posedge clk);
        #1;
      end
      chk("mid_read_point", m_address[1:0], 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear_exp();
      chk_reset();
      repeat (10) @(posedge clk);
      #1;
      chk("post_reset_idle", busy, 0);
    end else begin
      for (int i = 0; i < 2000 && !done; i++) begin
        @(posedge clk);
        #1;
      end
      chk("done_seen", done, 1);
      if (!done) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_exp();
      end else begin
        abort = 1'b0;
        ab_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("left_reads", exp_rd.size(), 0);
        chk("left_descs", exp_desc.size(), 0);
        chk("left_writes", exp_wr.size(), 0);
        chk("left_status", exp_st.size(), 0);
      end
    end
  endtask
  initial begin
    logic [AW-1:0] bs [4];
    logic [31:0] nx;
    int n, u, am;
    bit dup;
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    reset = 1'b0;
    put_desc(11'h010, $urandom, 1, 1, 16'h0040);
    run(11'h010, 0, 0, 0, 0);
    put_desc(11'h000, 32'h0000_0100, 1, 0, 16'h0011);
    put_desc(11'h100, 32'h0000_07FC, 1, 0, 16'h0022);
    put_desc(11'h7FC, $urandom, 1, 1, 16'h0033);
    run(11'h000, 0, 0, 0, 0);
    put_desc(11'h7FC, {21'($urandom), 11'h7FD}, 1, 0, 16'h0044);
    run(11'h7FC, 2, 1, 0, 0);
    put_desc(11'h020, 32'h0000_0040, 1, 0, 16'h0055);
    put_desc(11'h040, $urandom, 0, 0, 16'h0066);
    run(11'h020, 0, 0, 0, 0);
    put_desc(11'h080, $urandom, 1, 1, 16'h0077);
    run(11'h080, 1, 0, 0, 0);
    run(11'h080, 2, 0, 0, 0);
    put_desc(11'h200, $urandom, 1, 1, 16'h0088);
    run(11'h200, 0, 0, 2, 0);
    put_desc(11'h300, $urandom, 1, 1, 16'h0099);
    run(11'h300, 0, 0, 0, 1);
    run(11'h300, 0, 0, 0, 0);
    for (int t = 0; t < 24; t++) begin
      n = $urandom_range(1, 4);
      u = $urandom_range(0, 6);
      for (int i = 0; i < n; i++)
        do begin
          bs[i] = AW'($urandom_range(0, 511) * 4);
          dup = 0;
          for (int j = 0; j < i; j++) if (bs[j] == bs[i]) dup = 1;
        end while (dup);
      for (int i = 0; i < n; i++) begin
        nx = $urandom;
        if (i < n - 1) nx[AW-1:0] = bs[i+1] | AW'($urandom_range(0, 3));
        put_desc(bs[i], nx, i != u, i == n - 1, 16'($urandom));
      end
      am = $urandom_range(0, 3);
      run(bs[0] | AW'($urandom_range(0, 3)), am == 3 ? 0 : am, $urandom_range(0, n - 1), $urandom_range(0, 1), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
